// File: rtl/countdown_scan_ctrl.sv
// countdown_scan_ctrl: single-digit countdown shown on an 8x8 red/green matrix.
// Runs the 1 s decrement tick and the IDLE/RUN/PAUSE/DONE state machine, and
// scans the matrix one row at a time.
// Optional build macro COUNTDOWN_SCAN_CTRL_BLINK_EN: blink the red digit in DONE.
module countdown_scan_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned SCAN_DIV  = 1,
  parameter int unsigned START_VAL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] row,
  output logic [7:0] colr,
  output logic [7:0] colg,
  output logic [3:0] digit,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [9:0] TICK_LAST   = 10'(TICK_DIV - 1);
  localparam logic [7:0] SCAN_LAST   = 8'(SCAN_DIV - 1);
  localparam logic [3:0] START_DIGIT = 4'(START_VAL);

  state_t      state_reg, state_next;
  logic [3:0]  digit_reg, digit_next;
  logic [9:0]  tick_cnt_reg, tick_cnt_next;
  logic        tick_wrap;
  logic        blank;

  logic [7:0]  scan_div_reg;
  logic [2:0]  scan_idx_reg;
  logic [7:0]  row_reg, colr_reg, colg_reg;
  logic [7:0]  pattern;
  logic [7:0]  colr_next, colg_next;

  // Font ROM: rows 1..6 of each digit, row 1 in the top byte. Rows 0 and 7
  // are always blank so the digit never touches the matrix edge.
  function automatic logic [7:0] glyph(input logic [3:0] d, input logic [2:0] r);
    logic [47:0] rows;
    case (d)
      4'd0:    rows = 48'h3C_66_66_66_66_3C;
      4'd1:    rows = 48'h18_38_18_18_18_3C;
      4'd2:    rows = 48'h3C_66_0C_18_30_7E;
      4'd3:    rows = 48'h3C_06_1C_06_66_3C;
      4'd4:    rows = 48'h0C_1C_2C_4C_7E_0C;
      4'd5:    rows = 48'h7E_60_7C_06_66_3C;
      4'd6:    rows = 48'h3C_60_7C_66_66_3C;
      4'd7:    rows = 48'h7E_06_0C_18_18_18;
      4'd8:    rows = 48'h3C_66_3C_66_66_3C;
      4'd9:    rows = 48'h3C_66_66_3E_06_3C;
      default: rows = 48'h0;
    endcase
    if (r == 3'd0 || r == 3'd7) begin
      return 8'h00;
    end
    return rows[(6 - int'(r)) * 8 +: 8];
  endfunction

  // The tick counter reaching its last value is the one-cycle decrement tick.
  assign tick_wrap = (tick_cnt_reg == TICK_LAST);

  // Next-state, digit and tick-counter logic; start overrides everything.
  always_comb begin
    state_next    = state_reg;
    digit_next    = digit_reg;
    tick_cnt_next = tick_cnt_reg;
    if (start) begin
      digit_next    = START_DIGIT;
      tick_cnt_next = '0;
      state_next    = (START_VAL == 0) ? ST_DONE : ST_RUN;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tick_cnt_next = '0;
        end
        ST_RUN: begin
          tick_cnt_next = tick_wrap ? 10'd0 : tick_cnt_reg + 10'd1;
          if (pause) begin
            state_next = ST_PAUSE;
          end
          if (tick_wrap) begin
            if (digit_reg > 4'd1) begin
              digit_next = digit_reg - 4'd1;
            end else begin
              // Reaching zero takes priority over a simultaneous pause.
              digit_next = '0;
              state_next = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_next = ST_RUN;
          end
        end
        ST_DONE: begin
          digit_next = '0;
`ifdef COUNTDOWN_SCAN_CTRL_BLINK_EN
          tick_cnt_next = tick_wrap ? 10'd0 : tick_cnt_reg + 10'd1;
`else
          tick_cnt_next = '0;
`endif
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      digit_reg    <= START_DIGIT;
      tick_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      digit_reg    <= digit_next;
      tick_cnt_reg <= tick_cnt_next;
    end
  end

`ifdef COUNTDOWN_SCAN_CTRL_BLINK_EN
  logic blink_reg, blink_next;

  // Blink flag toggles on every tick wrap while DONE, and is 0 anywhere else.
  always_comb begin
    blink_next = 1'b0;
    if (!start && state_reg == ST_DONE) begin
      blink_next = blink_reg ^ tick_wrap;
    end
  end

  // Blink flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_reg <= 1'b0;
    end else begin
      blink_reg <= blink_next;
    end
  end

  assign blank = blink_reg;
`else
  assign blank = 1'b0;
`endif

  // Scan divider and row index run freely in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_div_reg <= '0;
      scan_idx_reg <= '0;
    end else if (scan_div_reg == SCAN_LAST) begin
      scan_div_reg <= '0;
      scan_idx_reg <= scan_idx_reg + 3'd1;
    end else begin
      scan_div_reg <= scan_div_reg + 8'd1;
    end
  end

  assign pattern = glyph(digit_reg, scan_idx_reg);

  // Column colour chosen from the registered state.
  always_comb begin
    colr_next = '0;
    colg_next = '0;
    case (state_reg)
      ST_IDLE, ST_RUN: begin
        colg_next = pattern;
      end
      ST_PAUSE: begin
        colr_next = pattern;
        colg_next = pattern;
      end
      ST_DONE: begin
        if (!blank) begin
          colr_next = pattern;
        end
      end
      default: begin
        colr_next = '0;
      end
    endcase
  end

  // Row and column pins update together so a frame never mixes two rows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_reg  <= 8'hFF;
      colr_reg <= '0;
      colg_reg <= '0;
    end else begin
      row_reg  <= ~(8'h01 << scan_idx_reg);
      colr_reg <= colr_next;
      colg_reg <= colg_next;
    end
  end

  assign row   = row_reg;
  assign colr  = colr_reg;
  assign colg  = colg_reg;
  assign digit = digit_reg;
  assign done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_countdown_scan_ctrl.sv
// Testbench for countdown_scan_ctrl: cycle scoreboard plus directed checks.
module tb_countdown_scan_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int SCAN_DIV  = 1;
  localparam int START_VAL = 5;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

`ifdef COUNTDOWN_SCAN_CTRL_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       start_z = 1'b0;
  logic [7:0] row, colr, colg;
  logic [3:0] digit;
  logic       done;
  logic [7:0] row_z, colr_z, colg_z;
  logic [3:0] digit_z;
  logic       done_z;

  always #5 clk = ~clk;

  countdown_scan_ctrl #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV),
    .START_VAL(START_VAL)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .pause(pause),
    .row  (row),
    .colr (colr),
    .colg (colg),
    .digit(digit),
    .done (done)
  );

  // Second instance exercising the START_VAL==0 boundary.
  countdown_scan_ctrl #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV),
    .START_VAL(0)
  ) u_dut_z (
    .clk  (clk),
    .rst  (rst),
    .start(start_z),
    .pause(1'b0),
    .row  (row_z),
    .colr (colr_z),
    .colg (colg_z),
    .digit(digit_z),
    .done (done_z)
  );

  // Font: [digit][row], row 0 is the top row.
  logic [7:0] font [10][8] = '{
    '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h00, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h3C, 8'h00},
    '{8'h00, 8'h3C, 8'h66, 8'h0C, 8'h18, 8'h30, 8'h7E, 8'h00},
    '{8'h00, 8'h3C, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h00},
    '{8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h00, 8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h00, 8'h7E, 8'h06, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h00},
    '{8'h00, 8'h3C, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h3C, 8'h00}
  };

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic [3:0] digit;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Reference model state (value seen after the most recent edge).
  int         m_st, m_dig, m_cnt, m_idx, m_sdiv;
  bit         m_blink;
  logic [7:0] m_row, m_colr, m_colg;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (txn %0d)", tag, act, exp, n_txn);
    end
  endtask

  task automatic model_reset();
    m_st    = S_IDLE;
    m_dig   = START_VAL;
    m_cnt   = 0;
    m_idx   = 0;
    m_sdiv  = 0;
    m_blink = 1'b0;
    m_row   = 8'hFF;
    m_colr  = 8'h00;
    m_colg  = 8'h00;
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic model_step(input logic s, input logic p);
    logic [7:0] pat;
    bit         tick;
    if (!rst) begin
      model_reset();
      return;
    end
    pat   = font[m_dig][m_idx];
    m_row = ~(8'h01 << m_idx);
    case (m_st)
      S_PAUSE: begin m_colr = pat;  m_colg = pat;  end
      S_DONE:  begin m_colr = m_blink ? 8'h00 : pat; m_colg = 8'h00; end
      default: begin m_colr = 8'h00; m_colg = pat; end
    endcase
    if (m_sdiv == SCAN_DIV - 1) begin
      m_sdiv = 0;
      m_idx  = (m_idx + 1) % 8;
    end else begin
      m_sdiv++;
    end
    tick = (m_cnt == TICK_DIV - 1) && (m_st == S_RUN || (BLINK_ON && m_st == S_DONE));
    if (s) begin
      m_dig   = START_VAL;
      m_cnt   = 0;
      m_blink = 1'b0;
      m_st    = (START_VAL == 0) ? S_DONE : S_RUN;
    end else begin
      case (m_st)
        S_RUN: begin
          if (tick) begin
            m_cnt = 0;
            m_dig = m_dig - 1;
          end else begin
            m_cnt++;
          end
          if (tick && m_dig == 0) m_st = S_DONE;
          else if (p)             m_st = S_PAUSE;
        end
        S_PAUSE: if (p) m_st = S_RUN;
        S_DONE: begin
          if (BLINK_ON) begin
            if (tick) begin
              m_cnt   = 0;
              m_blink = !m_blink;
            end else begin
              m_cnt++;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  // One transaction: drive inputs, push expectation, compare after the edge.
  task automatic cycle(input logic s, input logic p);
    exp_t e;
    @(negedge clk);
    start = s;
    pause = p;
    model_step(s, p);
    exp_q.push_back('{row: m_row, colr: m_colr, colg: m_colg,
                      digit: 4'(m_dig), done: (m_st == S_DONE)});
    @(posedge clk);
    #1;
    n_txn++;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("row", 32'(row), 32'(e.row));
      check("colr", 32'(colr), 32'(e.colr));
      check("colg", 32'(colg), 32'(e.colg));
      check("digit", 32'(digit), 32'(e.digit));
      check("done", 32'(done), 32'(e.done));
      if (row == 8'hFE || row == 8'h7F) begin
        check("blank_r", 32'(colr), 32'd0);
        check("blank_g", 32'(colg), 32'd0);
      end
    end
    $display("txn %0d: start=%b pause=%b row=%h colr=%h colg=%h digit=%0d done=%b",
             n_txn, s, p, row, colr, colg, digit, done);
  endtask

  task automatic run_until_digit(input int d, input int limit);
    int k = 0;
    while (!(m_st == S_RUN && m_dig == d) && k < limit) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    check("wait_digit", 32'(m_st == S_RUN && m_dig == d), 32'd1);
  endtask

  task automatic run_until_tick(input int limit);
    int k = 0;
    while (!(m_st == S_RUN && m_cnt == TICK_DIV - 1) && k < limit) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    check("wait_tick", 32'(m_st == S_RUN && m_cnt == TICK_DIV - 1), 32'd1);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rst = 1'b1;

    // Idle scanning, then a pause in IDLE that must be ignored.
    repeat (10) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    // Full countdown from START_VAL to DONE, then hold in DONE.
    cycle(1'b1, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      cycle(1'b0, 1'b0);
      if (k % 4 == 0 && k <= 20) check("cd_digit", 32'(digit), 32'(5 - k / 4));
      if (k == 19) check("cd_done_early", 32'(done), 32'd0);
      if (k == 20) check("cd_done", 32'(done), 32'd1);
    end
    repeat (12) cycle(1'b0, 1'b0);

    // Pause two cycles after start, hold 10 cycles, resume.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0);
    check("pause_digit", 32'(digit), 32'd5);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("resume_d1", 32'(digit), 32'd5);
    cycle(1'b0, 1'b0);
    check("resume_d2", 32'(digit), 32'd4);
    repeat (2) cycle(1'b0, 1'b0);

    // Restart while running with digit 2.
    run_until_digit(2, 40);
    cycle(1'b1, 1'b0);
    check("restart_digit", 32'(digit), 32'd5);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 1'b0);
      check("restart_done", 32'(done), 32'd0);
      if (k == 3) check("restart_hold", 32'(digit), 32'd5);
      if (k == 4) check("restart_dec", 32'(digit), 32'd4);
    end

    // Simultaneous start and pause: start wins.
    cycle(1'b1, 1'b1);
    check("sp_digit", 32'(digit), 32'd5);
    repeat (3) cycle(1'b0, 1'b0);

    // Tick and pause in the same cycle: decrement applied, then PAUSE.
    run_until_tick(20);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);

    // Asynchronous reset mid-RUN with digit 3.
    run_until_digit(3, 40);
    cycle(1'b0, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_row", 32'(row), 32'hFF);
    check("arst_colr", 32'(colr), 32'd0);
    check("arst_colg", 32'(colg), 32'd0);
    check("arst_digit", 32'(digit), 32'd5);
    check("arst_done", 32'(done), 32'd0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rst = 1'b1;
    repeat (10) cycle(1'b0, 1'b0);

    // START_VAL==0 instance: start goes straight to DONE.
    @(negedge clk);
    check("z_idle_done", 32'(done_z), 32'd0);
    check("z_idle_digit", 32'(digit_z), 32'd0);
    start_z = 1'b1;
    @(posedge clk);
    #1;
    check("z_done", 32'(done_z), 32'd1);
    check("z_digit", 32'(digit_z), 32'd0);
    @(negedge clk);
    start_z = 1'b0;
    @(posedge clk);
    #1;
    check("z_done_hold", 32'(done_z), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_scan_ctrl.md
Name: countdown_scan_ctrl

Overview:
- Sequences a single-digit countdown (START_VAL down to 0) on an 8x8 red/green dot matrix.
- Generates the 1 s decrement tick, runs the start/pause/done state machine, and time-multiplexes the matrix one row at a time.
- Sits between the board push-button pulses and the matrix row/column pins.

Parameters:
- TICK_DIV, 1000: clk cycles per countdown tick (1 s at 1 kHz); legal 2..1023.
- SCAN_DIV, 1: clk cycles per scanned row; legal 1..255.
- START_VAL, 5: value loaded on start; legal 0..9.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  synchronous one-cycle pulse: (re)load START_VAL and run.
- pause  input  1  synchronous one-cycle pulse: toggle RUN/PAUSE.
- row  output  8  row select, active-low one-hot; bit i low = row i driven.
- colr  output  8  red column data, active-high.
- colg  output  8  green column data, active-high.
- digit  output  4  current countdown value, 0..9.
- done  output  1  high while in DONE.

Behaviour:
- Reset (rst low, async): state IDLE, digit=START_VAL, tick counter 0, scan index 0, scan divider 0, row=8'hFF, colr=0, colg=0, done=0.
- Tick counter:
  - Counts 0..TICK_DIV-1 only in RUN; holds its value in PAUSE; is 0 in IDLE and DONE.
  - The tick pulse is internal, one cycle, asserted when count==TICK_DIV-1; the counter then wraps to 0.
  - Entering RUN via start clears the counter, so the first decrement occurs exactly TICK_DIV cycles after start is sampled.
- FSM (states IDLE, RUN, PAUSE, DONE; registered; done = state==DONE):
  - IDLE: start -> RUN, digit<=START_VAL. pause is ignored.
  - RUN: tick with digit>1 -> digit-1, stay in RUN. tick with digit==1 -> digit<=0, go to DONE. pause -> PAUSE.
  - PAUSE: pause -> RUN, tick counter resumes from its held value.
  - DONE: digit stays 0. pause is ignored.
  - start in any state: reload START_VAL, clear the tick counter, go to RUN.
  - start with START_VAL==0: go directly to DONE.
  - start and pause in the same cycle: start wins; pause is discarded.
  - tick and pause in the same cycle in RUN: the decrement is applied and state goes to PAUSE (or DONE if digit was 1).
- Scan:
  - Free-running in every state after reset.
  - The scan divider counts 0..SCAN_DIV-1. On wrap, the scan index advances 0->1->...->7->0.
  - row, colr and colg are registered and all update on the same edge, one cycle after the index changes; no mixed row/column frames.
  - row = ~(8'b1 << idx).
  - pattern = glyph(digit, idx), an 8-bit row from the fixed 10-entry font ROM.
  - Font rows 0 and 7 are 8'h00 for every digit; each of rows 1..6 is nonzero for every digit.
- Colour by state (sampled from registered state):
  - IDLE: colg=pattern, colr=0.
  - RUN: colg=pattern, colr=0.
  - PAUSE: colr=colg=pattern (yellow).
  - DONE: colr=pattern, colg=0.
- Width rules: digit is 4 bits and never wraps below 0 (DONE blocks further ticks). The tick counter is 10 bits and the scan divider is 8 bits.

Optional Feature:
- Macro: COUNTDOWN_SCAN_CTRL_BLINK_EN.
- Defined:
  - The tick counter keeps running in DONE, free-running 0..TICK_DIV-1 and starting from 0 on entry.
  - A blink flag toggles on each wrap, starting 0 on DONE entry.
  - While the flag is 1, colr=colg=0 (row scanning continues).
  - The flag is cleared on leaving DONE and on reset.
- Undefined: DONE shows steady red and the tick counter is held at 0.

Test Plan:
- Reset: drive rst low mid-RUN with digit=3 -> immediately row=8'hFF, colr=colg=0, digit=5, done=0. After release, row steps FE,FD,FB,...,7F,FE with SCAN_DIV=1.
- Full countdown (TICK_DIV=4, START_VAL=5): start at cycle 0 -> digit 4,3,2,1,0 at cycles 4,8,12,16,20. done=1 from cycle 20 and stays 1. colg=0 and colr equals the glyph row.
- Pause/resume (TICK_DIV=4): pause 2 cycles after start, hold 10 cycles, pause again -> digit=4 appears 2 cycles after resume. During PAUSE, colr==colg for every row.
- Restart: start while RUN with digit=2 -> digit=5 next cycle, the next decrement is TICK_DIV cycles later, and done stays 0.
- Simultaneous start+pause in RUN -> state RUN (colr=0), digit=5. A pause in IDLE -> no change.
- Blank rows: in every state, whenever row==8'hFE or row==8'h7F -> colr=colg=0. With BLINK_EN and TICK_DIV=4 in DONE -> columns are zero on alternate 4-cycle windows.
